// File: rtl/user_gpio_pkg.sv
// rtl/user_gpio_pkg.sv - shared constants and helpers for the user GPIO Wishbone block
package user_gpio_pkg;

  localparam int NGPIO_DEF = 27;

  // Word offsets, i.e. wbs_adr_i[7:2]
  localparam logic [5:0] OFF_OUT      = 6'h00;
  localparam logic [5:0] OFF_OEB      = 6'h01;
  localparam logic [5:0] OFF_IN       = 6'h02;
  localparam logic [5:0] OFF_RISE_EN  = 6'h03;
  localparam logic [5:0] OFF_FALL_EN  = 6'h04;
  localparam logic [5:0] OFF_STATUS   = 6'h05;
  localparam logic [5:0] OFF_DEBOUNCE = 6'h06;

  localparam logic [31:0] OEB_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] apply_sel(input logic [31:0] cur,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_sync_debounce.sv
// rtl/gpio_sync_debounce.sv - pad input synchroniser with prescaled sampling
// tick pulses the cycle after sampled/prev take a new sample.
module gpio_sync_debounce #(
  parameter int NGPIO       = 27,
  parameter int SYNC_STAGES = 2,
  parameter int DBW         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NGPIO-1:0] io_in,
  input  logic [DBW-1:0]   period,
  input  logic             prescale_clr,
  output logic [NGPIO-1:0] sampled,
  output logic [NGPIO-1:0] prev,
  output logic             tick
);

  logic [NGPIO-1:0] sync_q [SYNC_STAGES];
  logic [DBW-1:0]   cnt;
  logic             sample_en;

  assign sample_en = (cnt == period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cnt     <= '0;
      sampled <= '0;
      prev    <= '0;
      tick    <= 1'b0;
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (prescale_clr || sample_en) cnt <= '0;
      else                           cnt <= cnt + DBW'(1);
      tick <= sample_en;
      if (sample_en) begin
        prev    <= sampled;
        sampled <= sync_q[SYNC_STAGES-1];
      end
    end
  end

endmodule

// File: rtl/user_gpio_wb.sv
// rtl/user_gpio_wb.sv - Wishbone GPIO block for the user project pads
// Registers, edge interrupt and Wishbone decode; input conditioning lives in gpio_sync_debounce.
module user_gpio_wb
  import user_gpio_pkg::*;
#(
  parameter int          NGPIO       = NGPIO_DEF,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2,
  parameter int          DBW         = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NGPIO-1:0] io_in,
  output logic [NGPIO-1:0] io_out,
  output logic [NGPIO-1:0] io_oeb,
  output logic             irq_o
);

  // Reset asserts immediately but releases on a clock edge
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [NGPIO-1:0] out_q, oeb_q, rise_en_q, fall_en_q, status_q;
  logic [DBW-1:0]   debounce_q;
  logic [NGPIO-1:0] sampled, prev, edges, status_nxt;
  logic             tick;
  logic             hit, wr;
  logic [5:0]       off;
  logic [31:0]      rdata, merged, clr;

  assign off    = wbs_adr_i[7:2];
  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr     = hit & ~wbs_ack_o & wbs_we_i;
  assign io_out = out_q;
  assign io_oeb = oeb_q;

  gpio_sync_debounce #(
    .NGPIO       (NGPIO),
    .SYNC_STAGES (SYNC_STAGES),
    .DBW         (DBW)
  ) u_sync (
    .clk          (wb_clk_i),
    .rst_n        (rst_n),
    .io_in        (io_in),
    .period       (debounce_q),
    .prescale_clr (wr && (off == OFF_DEBOUNCE)),
    .sampled      (sampled),
    .prev         (prev),
    .tick         (tick)
  );

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OUT:      rdata = 32'(out_q);
      OFF_OEB:      rdata = 32'(oeb_q);
      OFF_IN:       rdata = 32'(sampled);
      OFF_RISE_EN:  rdata = 32'(rise_en_q);
      OFF_FALL_EN:  rdata = 32'(fall_en_q);
      OFF_STATUS:   rdata = 32'(status_q);
      OFF_DEBOUNCE: rdata = 32'(debounce_q);
      default:      rdata = '0;
    endcase
  end

  // Merging with the current value keeps unselected bytes intact
  assign merged = apply_sel(rdata, wbs_dat_i, wbs_sel_i);
  assign clr    = apply_sel(32'h0, wbs_dat_i, wbs_sel_i);

  always_comb begin
    edges = '0;
    if (tick) edges = (sampled & ~prev & rise_en_q) | (~sampled & prev & fall_en_q);
    // A new edge in the same cycle as its W1C must survive
    status_nxt = status_q | edges;
    if (wr && (off == OFF_STATUS)) status_nxt = (status_q & ~clr[NGPIO-1:0]) | edges;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= hit & ~wbs_ack_o;
      wbs_dat_o <= (hit & ~wbs_ack_o & ~wbs_we_i) ? rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      oeb_q      <= OEB_RST[NGPIO-1:0];
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      debounce_q <= '0;
    end else if (wr) begin
      case (off)
        OFF_OUT:      out_q      <= merged[NGPIO-1:0];
        OFF_OEB:      oeb_q      <= merged[NGPIO-1:0];
        OFF_RISE_EN:  rise_en_q  <= merged[NGPIO-1:0];
        OFF_FALL_EN:  fall_en_q  <= merged[NGPIO-1:0];
        OFF_DEBOUNCE: debounce_q <= merged[DBW-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      irq_o    <= 1'b0;
    end else begin
      status_q <= status_nxt;
      irq_o    <= |status_q;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], merged, clr};

endmodule

// File: tb/tb_user_gpio_wb.sv
// tb/tb_user_gpio_wb.sv - directed bench for user_gpio_wb with a read-data scoreboard
module tb_user_gpio_wb;

  localparam int          NG = 27;
  localparam logic [31:0] B  = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = '0, dati = '0;
  logic          ack;
  logic [31:0]   dato;
  logic [NG-1:0] io_in = '0;
  logic [NG-1:0] io_out, io_oeb;
  logic          irq;

  int            n_assert = 0;
  int            n_fail = 0;
  logic [31:0]   exp_q[$];
  string         tag_q[$];
  logic          last_acked;
  int            last_lat;
  logic [31:0]   last_rd;

  always #5 clk = ~clk;

  user_gpio_wb dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n_i),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dati),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dato),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .irq_o      (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dati = d; sel = s;
    last_acked = 1'b0; last_lat = 0; last_rd = '0;
    for (int i = 1; i <= 8 && !last_acked; i++) begin
      @(negedge clk);
      if (ack) begin
        last_acked = 1'b1;
        last_lat   = i;
        last_rd    = dato;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_cycle(1'b1, a, d, s);
    check("write_ack", 32'(last_acked), 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] expv, input string tag);
    logic [31:0] e;
    string       t;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    wb_cycle(1'b0, a, 32'h0, 4'hF);
    check({tag, "_ack"}, 32'(last_acked), 32'd1);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, last_rd, e);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dato, 32'd0);
    check("rst_io_oeb", 32'(io_oeb), 32'h07FF_FFFF);
    check("rst_io_out", 32'(io_out), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk);

    wb_read(B + 32'h04, 32'h07FF_FFFF, "oeb_rst");
    check("ack_latency", 32'(last_lat), 32'd1);
    @(negedge clk);
    check("ack_one_cycle", 32'(ack), 32'd0);
    check("dat_idle_zero", dato, 32'd0);
    wb_read(B, 32'h0, "out_rst");

    wb_write(B, 32'hFFFF_FFFF, 4'b0011);
    check("io_out_sel", 32'(io_out), 32'h0000_FFFF);
    wb_read(B, 32'h0000_FFFF, "out_sel_rd");
    wb_write(B, 32'hAB00_0000, 4'b1000);
    wb_read(B, 32'h0300_FFFF, "out_byte3");

    // Debounce period 4 cycles: bit 5 must appear within SYNC_STAGES+4 cycles
    wb_write(B + 32'h18, 32'd3, 4'hF);
    wb_read(B + 32'h18, 32'd3, "debounce_rd");
    io_in[5] = 1'b1;
    repeat (5) @(negedge clk);
    wb_read(B + 32'h08, 32'h20, "in_debounced");

    // Glitch on bit 7 placed between the ticks that follow the prescaler reset
    wb_write(B + 32'h0C, 32'h80, 4'hF);
    wb_write(B + 32'h18, 32'd3, 4'hF);
    repeat (2) @(negedge clk);
    io_in[7] = 1'b1;
    repeat (2) @(negedge clk);
    io_in[7] = 1'b0;
    repeat (10) @(negedge clk);
    wb_read(B + 32'h08, 32'h20, "glitch_in");
    wb_read(B + 32'h14, 32'h0, "glitch_status");
    check("glitch_irq", 32'(irq), 32'd0);

    wb_write(B + 32'h0C, 32'h20, 4'hF);
    io_in[5] = 1'b0;
    repeat (10) @(negedge clk);
    wb_read(B + 32'h08, 32'h0, "in_fall");
    wb_read(B + 32'h14, 32'h0, "fall_no_en");
    io_in[5] = 1'b1;
    repeat (10) @(negedge clk);
    wb_read(B + 32'h14, 32'h20, "rise_status");
    check("rise_irq", 32'(irq), 32'd1);
    io_in[5] = 1'b0;
    repeat (10) @(negedge clk);
    wb_read(B + 32'h14, 32'h20, "fall_keeps_status");
    wb_write(B + 32'h0C, 32'h0, 4'hF);
    wb_read(B + 32'h14, 32'h20, "en_clear_keeps_status");
    wb_write(B + 32'h0C, 32'h20, 4'hF);
    wb_write(B + 32'h14, 32'h20, 4'b0010);
    wb_read(B + 32'h14, 32'h20, "w1c_sel_off");
    wb_write(B + 32'h14, 32'h20, 4'b0001);
    @(negedge clk);
    check("irq_clear", 32'(irq), 32'd0);
    wb_read(B + 32'h14, 32'h0, "w1c_status");

    // Collision: the W1C commit edge is the edge that flags the new rise
    wb_write(B + 32'h18, 32'd0, 4'hF);
    io_in[5] = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_collision_irq", 32'(irq), 32'd1);
    io_in[5] = 1'b0;
    repeat (6) @(negedge clk);
    io_in[5] = 1'b1;
    repeat (2) @(negedge clk);
    wb_write(B + 32'h14, 32'h20, 4'hF);
    check("collision_irq0", 32'(irq), 32'd1);
    @(negedge clk);
    check("collision_irq1", 32'(irq), 32'd1);
    wb_read(B + 32'h14, 32'h20, "collision_status");

    wb_read(B + 32'h40, 32'h0, "unmapped_rd");
    wb_cycle(1'b0, B + 32'h100, 32'h0, 4'hF);
    check("miss_no_ack", 32'(last_acked), 32'd0);

    wb_write(B, 32'h0000_1234, 4'hF);
    check("io_out_pre_rst", 32'(io_out), 32'h0000_1234);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B + 32'h04; sel = 4'hF;
    @(posedge clk);
    #1;
    check("ack_before_rst", 32'(ack), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check("ack_rst_async", 32'(ack), 32'd0);
    check("dat_rst_async", dato, 32'd0);
    check("io_out_rst_async", 32'(io_out), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk);
    wb_read(B, 32'h0, "out_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
